fcn_seq_ctrl: RTL
=================

FCN_SEQ_CTRL -- requirements
Module: fcn_seq_ctrl

Interface
REQ-001 SHALL have parameters: IN1_N, default 132, input vector length; OUT1_M, default 10, FC1 neuron count; WDOG_CYC, default 4096, watchdog limit in cycles.
REQ-002 SHALL have ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  byte stream valid.
- s_ready  out  1  byte stream ready.
- s_data  in  8  signed int8 payload.
- s_last  in  1  final byte of job.
- cfg_load_w  in  1  job carries weights; sampled on first accepted byte.
- in_vec_wr  out  1  vector bulk-write strobe.
- in_vec_flat  out  IN1_N*8  vector, element i at bits [8i+7:8i].
- fc1_w_wr_all  out  1  FC1 bulk-write strobe.
- fc1_w_flat  out  OUT1_M*IN1_N*8  FC1 weights, element (n,j) at index n*IN1_N+j.
- fc2_w_wr_all  out  1  FC2 bulk-write strobe.
- fc2_w_flat  out  OUT1_M*8  FC2 weights.
- fcn_start  out  1  compute start pulse.
- fcn_done  in  1  compute done.
- fcn_logit  in  24  signed result.
- res_valid  out  1  response valid.
- res_ready  in  1  response ready.
- res_logit  out  24  signed result.
- res_err  out  1  job error.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 SHALL implement states IDLE, LD_FC1, LD_FC2, LD_VEC, DRAIN, WR, START, WAIT, RESP.
REQ-004 SHALL drive s_ready=1 only in IDLE, LD_FC1, LD_FC2, LD_VEC and DRAIN; a byte transfers on s_valid&s_ready.
REQ-005 SHALL handle the first accepted byte in IDLE as element 0 of the job:
- cfg_load_w=1: FC1 element 0, state goes to LD_FC1.
- cfg_load_w=0: vector element 0, state goes to LD_VEC.
REQ-006 SHALL accept job order FC1 (OUT1_M*IN1_N bytes, neuron-major), then FC2 (OUT1_M bytes), then vector (IN1_N bytes); weight sections are present only when cfg_load_w=1.
REQ-007 SHALL use a byte counter that resets to 0 at each section boundary; the last byte of a section advances the state to the next section.
REQ-008 SHALL treat s_last on the final vector byte as a correct frame and go to WR.
REQ-009 SHALL treat s_last on any earlier byte as a short frame: res_err=1, res_logit=0, go to RESP, and leave weights_valid unchanged.
REQ-010 SHALL treat a final vector byte without s_last as a long frame: go to DRAIN, discard bytes up to and including s_last, then go to RESP with res_err=1.
REQ-011 SHALL treat cfg_load_w=0 while weights_valid=0 as an error: go to DRAIN, then go to RESP with res_err=1.
REQ-012 SHALL in WR pulse in_vec_wr for one cycle, plus fc1_w_wr_all and fc2_w_wr_all when the job loaded weights; SHALL set weights_valid=1 when weights were loaded.
REQ-013 SHALL pulse fcn_start in START for one cycle, exactly 2 cycles after the final byte accept.
REQ-014 SHALL in WAIT capture fcn_logit into res_logit on the cycle fcn_done=1, set res_err=0, and go to RESP.
REQ-015 SHALL hold res_valid=1 and res_logit/res_err stable in RESP until res_ready=1, then return to IDLE; fcn_done outside WAIT SHALL be ignored.
REQ-016 SHALL hold weight buffers between jobs so that later jobs with cfg_load_w=0 reuse them; a short frame SHALL leave the weight buffer partially overwritten, with weights_valid unchanged.

Reset
REQ-017 SHALL on rst_n=0 (any state, mid-job included) asynchronously force state=IDLE, counters=0, weights_valid=0, and all outputs and flat buffers to 0.

Configuration
REQ-018 SHALL compile a watchdog when FCN_SEQ_CTRL_WDOG_EN is defined:
- The counter clears on entry to WAIT.
- If WDOG_CYC cycles pass without fcn_done, go to RESP with res_err=1 and res_logit=0.
- Without the macro, WAIT has no time limit and no watchdog logic is present.

Verification
REQ-019 Full load: cfg_load_w=1; FC1(n,j)=n+1; FC2=1; vec[i]=(i%8)-3; s_last on byte 1462; stub fcn returns 3190 -> one-cycle wr strobes, fcn_start 2 cycles later, res_logit=3190, res_err=0.
REQ-020 Weight reuse: second job with cfg_load_w=0 and 132 bytes -> only in_vec_wr pulses, fc1/fc2 buffers unchanged, result captured.
REQ-021 Framing: s_last on byte 50 -> RESP with res_err=1, no fcn_start; 140-byte vector job -> 8 extra bytes drained, res_err=1.
REQ-022 No weights: cfg_load_w=0 right after reset -> stream drained to s_last, res_err=1, no strobes.
REQ-023 Backpressure and reset: res_ready held low 20 cycles -> res_valid and res_logit stable for all 20; rst_n asserted mid-LD_FC1 -> all outputs 0 and a following cfg_load_w=0 job errors.
REQ-024 With FCN_SEQ_CTRL_WDOG_EN defined, WDOG_CYC=16 and fcn_done never asserted -> res_err=1 sixteen cycles after entering WAIT.

Source files
------------

// File: rtl/fcn_seq_ctrl.sv
// fcn_seq_ctrl -- byte-stream job sequencer for the FC network engine.
//
// Collects a job from an int8 byte stream into flat buffers (optional FC1
// and FC2 weights, then the input vector), bulk-writes them into the
// compute block, starts it, waits for its result and presents that result
// on a valid/ready response port. Frames that are too short or too long,
// and vector-only jobs issued before any weights were loaded, produce an
// error response instead of a computation.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last  job byte stream (signed int8 payload)
//   cfg_load_w                 job carries weights (sampled on first byte)
//   in_vec_wr, in_vec_flat     vector bulk-write strobe and buffer
//   fc1_w_wr_all, fc1_w_flat   FC1 bulk-write strobe and buffer (n*IN1_N+j)
//   fc2_w_wr_all, fc2_w_flat   FC2 bulk-write strobe and buffer
//   fcn_start, fcn_done, fcn_logit  compute handshake and result
//   res_valid/res_ready/res_logit/res_err  job response
//   busy                       high whenever the sequencer is not idle
//
// Build option: define FCN_SEQ_CTRL_WDOG_EN to add a watchdog that aborts
// WAIT with an error after WDOG_CYC cycles without fcn_done.
//
// state  | meaning
// IDLE   | waiting for the first byte of a job
// LD_FC1 | loading FC1 weights, neuron-major
// LD_FC2 | loading FC2 weights
// LD_VEC | loading the input vector
// DRAIN  | discarding bytes up to s_last after a framing/config error
// WR     | one-cycle bulk-write strobes
// START  | one-cycle compute start pulse
// WAIT   | waiting for fcn_done
// RESP   | holding the response until res_ready

module fcn_seq_ctrl #(
  parameter int IN1_N    = 132,
  parameter int OUT1_M   = 10,
  parameter int WDOG_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [7:0]                   s_data,
  input  logic                         s_last,
  input  logic                         cfg_load_w,
  output logic                         in_vec_wr,
  output logic [IN1_N*8-1:0]           in_vec_flat,
  output logic                         fc1_w_wr_all,
  output logic [OUT1_M*IN1_N*8-1:0]    fc1_w_flat,
  output logic                         fc2_w_wr_all,
  output logic [OUT1_M*8-1:0]          fc2_w_flat,
  output logic                         fcn_start,
  input  logic                         fcn_done,
  input  logic [23:0]                  fcn_logit,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [23:0]                  res_logit,
  output logic                         res_err,
  output logic                         busy
);

  localparam int FC1_N = OUT1_M * IN1_N;
  localparam int CNT_W = $clog2(FC1_N + 1);
  localparam logic [CNT_W-1:0] FC1_LAST = CNT_W'(FC1_N - 1);
  localparam logic [CNT_W-1:0] FC2_LAST = CNT_W'(OUT1_M - 1);
  localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(IN1_N - 1);

  if (WDOG_CYC < 1) begin : g_bad_wdog
    $error("WDOG_CYC must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE, LD_FC1, LD_FC2, LD_VEC, DRAIN, WR, START, WAIT, RESP
  } state_t;

  state_t           state, state_nxt, cur;
  logic [CNT_W-1:0] cnt;
  logic             load_w, weights_valid;
  logic             acc, no_wts, sec_end, err_set, ready_nxt, wr_byte;
  logic             wdog_exp;

  assign acc    = s_valid & s_ready;
  assign no_wts = ~cfg_load_w & ~weights_valid;

  // Section the current byte belongs to; in IDLE the first byte already
  // belongs to the section selected by cfg_load_w, and cnt is 0 there.
  always_comb begin
    cur = state;
    if (state == IDLE) cur = cfg_load_w ? LD_FC1 : LD_VEC;
  end

  always_comb begin
    sec_end = 1'b0;
    case (cur)
      LD_FC1:  sec_end = (cnt == FC1_LAST);
      LD_FC2:  sec_end = (cnt == FC2_LAST);
      LD_VEC:  sec_end = (cnt == VEC_LAST);
      default: sec_end = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    case (state)
      IDLE, LD_FC1, LD_FC2, LD_VEC: begin
        if (acc) begin
          if (state == IDLE && no_wts) begin
            state_nxt = s_last ? RESP : DRAIN;
            err_set   = s_last;
          end else if (cur == LD_VEC && sec_end) begin
            state_nxt = s_last ? WR : DRAIN;
          end else if (s_last) begin
            state_nxt = RESP;
            err_set   = 1'b1;
          end else if (sec_end) begin
            state_nxt = (cur == LD_FC1) ? LD_FC2 : LD_VEC;
          end else begin
            state_nxt = cur;
          end
        end
      end
      DRAIN: begin
        if (acc && s_last) begin
          state_nxt = RESP;
          err_set   = 1'b1;
        end
      end
      WR:    state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (fcn_done) begin
          state_nxt = RESP;
        end else if (wdog_exp) begin
          state_nxt = RESP;
          err_set   = 1'b1;
        end
      end
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready_nxt = (state_nxt == IDLE) || (state_nxt == LD_FC1) ||
                     (state_nxt == LD_FC2) || (state_nxt == LD_VEC) ||
                     (state_nxt == DRAIN);

  // Bytes of a vector-only job without loaded weights are never stored.
  assign wr_byte = acc && (state != DRAIN) && !(state == IDLE && no_wts);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready       <= 1'b0;
      cnt           <= '0;
      load_w        <= 1'b0;
      weights_valid <= 1'b0;
      res_logit     <= '0;
      res_err       <= 1'b0;
      in_vec_flat   <= '0;
      fc1_w_flat    <= '0;
      fc2_w_flat    <= '0;
    end else begin
      // s_ready is registered so it stays low while reset is applied.
      s_ready <= ready_nxt;
      if (acc && state != DRAIN)
        cnt <= (state_nxt == cur) ? cnt + 1'b1 : '0;
      if (acc && state == IDLE)
        load_w <= cfg_load_w;
      if (wr_byte) begin
        case (cur)
          LD_FC1:  fc1_w_flat[int'(cnt)*8 +: 8]  <= s_data;
          LD_FC2:  fc2_w_flat[int'(cnt)*8 +: 8]  <= s_data;
          default: in_vec_flat[int'(cnt)*8 +: 8] <= s_data;
        endcase
      end
      if (state == WR && load_w)
        weights_valid <= 1'b1;
      if (err_set) begin
        res_err   <= 1'b1;
        res_logit <= '0;
      end else if (state == WAIT && fcn_done) begin
        res_err   <= 1'b0;
        res_logit <= fcn_logit;
      end
    end
  end

`ifdef FCN_SEQ_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_cnt;

  // Loaded while entering WAIT; expiry on the WDOG_CYC-th WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wdog_cnt <= '0;
    else if (state == START)
      wdog_cnt <= WD_W'(WDOG_CYC - 1);
    else if (state == WAIT && !wdog_exp)
      wdog_cnt <= wdog_cnt - 1'b1;
  end

  assign wdog_exp = (state == WAIT) && (wdog_cnt == '0);
`else
  assign wdog_exp = 1'b0;
`endif

  assign in_vec_wr    = (state == WR);
  assign fc1_w_wr_all = (state == WR) && load_w;
  assign fc2_w_wr_all = (state == WR) && load_w;
  assign fcn_start    = (state == START);
  assign res_valid    = (state == RESP);
  assign busy         = (state != IDLE);

endmodule
